// File: rtl/evt_sched_pkg.sv
// Shared types and helpers for the event-count scheduler slice.
package evt_sched_pkg;

    localparam int unsigned MAX_CH = 16;

    typedef logic [MAX_CH-1:0] ch_mask_t;

    // Bit width for a value range, never below 1 so single-entry ranges still get a wire.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/evt_count_sched_if.sv
// Event/clear/readout bus of evt_count_sched; EVT_SCHED_OVF_EN adds the sticky ovf_out flags.
interface evt_count_sched_if #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned MAX_COUNT = 1000
);
    localparam int unsigned CHW = evt_sched_pkg::clog2_min1(NUM_CH);
    localparam int unsigned CW  = evt_sched_pkg::clog2_min1(MAX_COUNT);

    logic [NUM_CH-1:0] evt_in;
    logic [NUM_CH-1:0] clr_in;
    logic              rd_req_in;
    logic [CHW-1:0]    rd_ch_in;
    logic              rd_valid_out;
    logic [CW-1:0]     rd_count_out;
    logic [NUM_CH-1:0] wrap_out;
    logic              busy_out;
    logic [NUM_CH-1:0] grant_out;
`ifdef EVT_SCHED_OVF_EN
    logic [NUM_CH-1:0] ovf_out;

    modport master (
        output evt_in, clr_in, rd_req_in, rd_ch_in,
        input  rd_valid_out, rd_count_out, wrap_out, busy_out, grant_out, ovf_out
    );
    modport slave (
        input  evt_in, clr_in, rd_req_in, rd_ch_in,
        output rd_valid_out, rd_count_out, wrap_out, busy_out, grant_out, ovf_out
    );
`else
    modport master (
        output evt_in, clr_in, rd_req_in, rd_ch_in,
        input  rd_valid_out, rd_count_out, wrap_out, busy_out, grant_out
    );
    modport slave (
        input  evt_in, clr_in, rd_req_in, rd_ch_in,
        output rd_valid_out, rd_count_out, wrap_out, busy_out, grant_out
    );
`endif

endinterface

// File: rtl/evt_count_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
    import evt_sched_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]               req,
    input  logic [clog2_min1(N)-1:0]   ptr,
    output logic [N-1:0]               gnt
);

    always_comb begin
        logic        found;
        int unsigned idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/evt_count_sched.sv
// Per-channel event counters sharing one round-robin serviced increment path.
// Optional EVT_SCHED_OVF_EN adds sticky per-channel overflow (dropped event) flags.
module evt_count_sched
    import evt_sched_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned MAX_COUNT  = 1000,
    parameter int unsigned PEND_DEPTH = 7
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    evt_count_sched_if.slave bus
);

    localparam int unsigned CHW = clog2_min1(NUM_CH);
    localparam int unsigned CW  = clog2_min1(MAX_COUNT);
    localparam int unsigned PW  = clog2_min1(PEND_DEPTH + 1);

    logic [CW-1:0]     count_q [NUM_CH];
    logic [PW-1:0]     pend_q  [NUM_CH];
    logic [CHW-1:0]    ptr_q;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    logic [NUM_CH-1:0] wrap_q;
    logic [CHW-1:0]    gnt_idx;
    logic [CW-1:0]     rd_sel;
    logic              rd_valid_q;
    logic [CW-1:0]     rd_count_q;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            req[i] = (pend_q[i] != '0);
        end
    end

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) gnt_idx = CHW'(i);
        end
    end

    // Readout mux; out-of-range channel selects nothing and reads as zero.
    always_comb begin
        rd_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.rd_ch_in == CHW'(i)) rd_sel = count_q[i];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                pend_q[i]  <= '0;
                count_q[i] <= '0;
            end
            wrap_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                wrap_q[i] <= 1'b0;
                if (bus.clr_in[i]) begin
                    pend_q[i]  <= '0;
                    count_q[i] <= '0;
                end else begin
                    if (bus.evt_in[i] && !gnt[i]) begin
                        if (pend_q[i] != PW'(PEND_DEPTH)) pend_q[i] <= pend_q[i] + 1'b1;
                    end else if (!bus.evt_in[i] && gnt[i]) begin
                        pend_q[i] <= pend_q[i] - 1'b1;
                    end
                    if (gnt[i]) begin
                        if (count_q[i] == CW'(MAX_COUNT - 1)) begin
                            count_q[i] <= '0;
                            wrap_q[i]  <= 1'b1;
                        end else begin
                            count_q[i] <= count_q[i] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Pointer follows the grant even when a clear cancels the increment.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ptr_q <= '0;
        end else if (gnt != '0) begin
            ptr_q <= (gnt_idx == CHW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_valid_q <= 1'b0;
            rd_count_q <= '0;
        end else begin
            rd_valid_q <= bus.rd_req_in;
            if (bus.rd_req_in) rd_count_q <= rd_sel;
        end
    end

`ifdef EVT_SCHED_OVF_EN
    logic [NUM_CH-1:0] ovf_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ovf_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (bus.clr_in[i]) begin
                    ovf_q[i] <= 1'b0;
                end else if (bus.evt_in[i] && !gnt[i] && pend_q[i] == PW'(PEND_DEPTH)) begin
                    ovf_q[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.ovf_out = ovf_q;
`endif

    assign bus.grant_out    = gnt;
    assign bus.busy_out     = |req;
    assign bus.wrap_out     = wrap_q;
    assign bus.rd_valid_out = rd_valid_q;
    assign bus.rd_count_out = rd_count_q;

endmodule
